// File: rtl/xor_share_arbiter.sv
// Shares one registered XOR datapath between N requesters with round-robin grant.
// Define XOR_SHARE_ARBITER_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module xor_share_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*WIDTH-1:0]     req_a,
  input  logic [N*WIDTH-1:0]     req_b,
  output logic [N-1:0]           req_ready,
  output logic [N-1:0]           resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  input  logic [N-1:0]           resp_ready,
  output logic [$clog2(N)-1:0]   grant_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int unsigned IDW = $clog2(N);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, res_q;
  logic [IDW-1:0]     grant_q;
  logic [N-1:0]       resp_valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [WIDTH-1:0]   win_a, win_b;

`ifdef XOR_SHARE_ARBITER_FIXED_PRIO_EN
  // Lowest asserted index wins; scanning downward leaves the lowest as the final assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q;

  // First valid after ptr with wrap; scanning distances downward keeps the nearest one.
  always_comb begin
    int unsigned j;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      j = (32'(ptr_q) + k) % N;
      if (req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDW'(N - 1);
    end else if (state_q == RESP && resp_ready[grant_q]) begin
      ptr_q <= grant_q;
    end
  end
`endif

  // Operand mux for the winning requester.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (IDW'(i) == win_idx) begin
        win_a = req_a[i*WIDTH +: WIDTH];
        win_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and same-cycle accept strobe; no accept while reset is asserted.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (win_found && rst_n) begin
          req_ready[win_idx] = 1'b1;
          state_d            = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            a_q     <= win_a;
            b_q     <= win_b;
            grant_q <= win_idx;
          end
        end
        EXEC: begin
          res_q        <= a_q ^ b_q;
          resp_valid_q <= N'(1) << grant_q;
        end
        RESP: begin
          if (resp_ready[grant_q]) begin
            resp_valid_q <= '0;
            cnt_q        <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = res_q;
  assign grant_id   = grant_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter: vector table plus backpressure, mid-op reset and counter wrap.
module tb_xor_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, resp_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_ready, resp_valid;
  logic [7:0]  resp_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] op_count;

  logic [3:0]  req_ready4, resp_valid4;
  logic [7:0]  resp_data4;
  logic [1:0]  grant_id4;
  logic        busy4;
  logic [3:0]  op_count4;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  xor_share_arbiter #(.N(4), .WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .grant_id(grant_id), .busy(busy), .op_count(op_count)
  );

  xor_share_arbiter #(.N(4), .WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready4), .resp_valid(resp_valid4), .resp_data(resp_data4),
    .resp_ready(resp_ready), .grant_id(grant_id4), .busy(busy4), .op_count(op_count4)
  );

  typedef struct {
    bit          rst_before;
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    int          g;
    logic [7:0]  d;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] onehot(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // One complete transaction with resp_ready tied high; entered and left at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    req_valid = v.valid;
    req_a = v.a;
    req_b = v.b;
    resp_ready = 4'hF;
    #1;
    chk({t, " req_ready"}, 32'(req_ready), 32'(onehot(v.g)));
    @(negedge clk);
    chk({t, " exec busy"}, 32'(busy), 32'd1);
    chk({t, " exec resp_valid"}, 32'(resp_valid), 32'd0);
    chk({t, " exec req_ready"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({t, " resp_valid"}, 32'(resp_valid), 32'(onehot(v.g)));
    chk({t, " resp_data"}, 32'(resp_data), 32'(v.d));
    chk({t, " grant_id"}, 32'(grant_id), 32'(v.g));
    exp_cnt++;
    @(negedge clk);
    chk({t, " op_count"}, 32'(op_count), 32'(exp_cnt));
    chk({t, " resp_valid clr"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    req_a = '0;
    req_b = '0;

    // Operand sets: req0 11^F0=E1, req1 22^F0=D2, req2 33^0F=3C, req3 44^0F=4B.
    vt[0] = '{1'b1, 4'b0100, 32'h00A5_0000, 32'h000F_0000, 2, 8'hAA};
    vt[1] = '{1'b1, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
`ifdef XOR_SHARE_ARBITER_FIXED_PRIO_EN
    vt[2] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
    vt[3] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
    vt[4] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
    vt[5] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
    vt[6] = '{1'b0, 4'b1010, 32'h4433_2211, 32'h0F0F_F0F0, 1, 8'hD2};
    vt[7] = '{1'b0, 4'b1010, 32'h4433_2211, 32'h0F0F_F0F0, 1, 8'hD2};
`else
    vt[2] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 1, 8'hD2};
    vt[3] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 2, 8'h3C};
    vt[4] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 3, 8'h4B};
    vt[5] = '{1'b0, 4'b1111, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};
    vt[6] = '{1'b0, 4'b1010, 32'h4433_2211, 32'h0F0F_F0F0, 1, 8'hD2};
    vt[7] = '{1'b0, 4'b1010, 32'h4433_2211, 32'h0F0F_F0F0, 3, 8'h4B};
`endif
    vt[8] = '{1'b0, 4'b0001, 32'h4433_2211, 32'h0F0F_F0F0, 0, 8'hE1};

    // Reset and idle.
    do_reset();
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_data", 32'(resp_data), 32'd0);
    chk("rst grant_id", 32'(grant_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst op_count", 32'(op_count), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].rst_before) do_reset();
      run_vec(vt[i], i);
    end

    // Backpressure on requester 1 while requester 3 waits; operands change after accept.
    do_reset();
    req_valid = 4'b0010;
    req_a = 32'h0000_5A00;
    req_b = 32'h0000_C300;
    resp_ready = 4'b0000;
    #1;
    chk("bp accept1", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = 4'b1000;
    req_a = 32'h1200_FF00;
    req_b = 32'h3400_C300;
    #1;
    chk("bp exec req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    resp_ready = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp stall%0d resp_valid", i), 32'(resp_valid), 32'b0010);
      chk($sformatf("bp stall%0d resp_data", i), 32'(resp_data), 32'h99);
      chk($sformatf("bp stall%0d req_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp grant_id", 32'(grant_id), 32'd1);
    resp_ready = 4'b0010;
    @(negedge clk);
    chk("bp accept3", 32'(req_ready), 32'b1000);
    chk("bp op_count", 32'(op_count), 32'd1);
    chk("bp resp_valid clr", 32'(resp_valid), 32'd0);
    resp_ready = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("bp r3 resp_valid", 32'(resp_valid), 32'b1000);
    chk("bp r3 resp_data", 32'(resp_data), 32'h26);
    chk("bp r3 grant_id", 32'(grant_id), 32'd3);
    req_valid = '0;
    @(negedge clk);
    chk("bp r3 op_count", 32'(op_count), 32'd2);

    // Reset asserted while in EXEC drops the transaction.
    req_valid = 4'b0100;
    req_a = 32'h00FF_0000;
    req_b = 32'h0011_0000;
    resp_ready = 4'hF;
    @(negedge clk);
    chk("mid exec busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req_valid = 4'b0101;
    req_a = 32'h0077_0081;
    req_b = 32'h0011_0018;
    @(negedge clk);
    chk("mid rst resp_valid", 32'(resp_valid), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst grant_id", 32'(grant_id), 32'd0);
    chk("mid rst op_count", 32'(op_count), 32'd0);
    chk("mid rst resp_data", 32'(resp_data), 32'd0);
    chk("mid rst req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    exp_cnt = 0;
    #1;
    chk("mid post req_ready", 32'(req_ready), 32'b0001);
    @(negedge clk);
    @(negedge clk);
    chk("mid post resp_valid", 32'(resp_valid), 32'b0001);
    chk("mid post resp_data", 32'(resp_data), 32'h99);
    req_valid = '0;
    @(negedge clk);
    chk("mid post op_count", 32'(op_count), 32'd1);

    // 17 back-to-back transactions: 4-bit counter wraps to 1.
    do_reset();
    req_valid = 4'b0001;
    req_a = 32'h0000_0003;
    req_b = 32'h0000_0005;
    resp_ready = 4'hF;
    repeat (51) @(negedge clk);
    chk("wrap op_count16", 32'(op_count), 32'd17);
    chk("wrap op_count4", 32'(op_count4), 32'd1);
    req_valid = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
